// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Contents:
//   - ALU opcode constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT.
//   - Sequencer state encoding: S_IDLE, S_EXEC, S_RESP.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for the ALU sharing arbiter.
// Signals:
//   - Two request channels (reqN_*): valid/ready plus opcode, operands,
//     immediate and source select.
//   - One response channel (rsp_*): valid/ready plus requester id, data,
//     zero flag and illegal-opcode error.
// Modports:
//   - master: requesters and response consumer.
//   - slave: the arbiter.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req0_imm;
    logic              req0_alusrc;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [DATA_W-1:0] req1_imm;
    logic              req1_alusrc;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_imm, req0_alusrc,
        output req1_valid, req1_op, req1_a, req1_b, req1_imm, req1_alusrc,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_imm, req0_alusrc,
        input  req1_valid, req1_op, req1_a, req1_b, req1_imm, req1_alusrc,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters.
// Ports:
//   - alucontrol: opcode.
//   - in1, in2: operands.
//   - inimm: immediate.
//   - alusrc: 1 selects inimm as the second operand.
//   - out: result.
//   - zero: high when out is zero.
// Unknown opcodes produce zero; the arbiter screens them separately.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   alucontrol,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] inimm,
    input  logic              alusrc,
    output logic [DATA_W-1:0] out,
    output logic              zero
);

    logic [DATA_W-1:0] opb;

    always_comb begin
        opb = alusrc ? inimm : in2;
        out = '0;
        case (alucontrol)
            ALU_AND: out = in1 & opb;
            ALU_OR:  out = in1 | opb;
            ALU_ADD: out = in1 + opb;
            ALU_SUB: out = in1 - opb;
            ALU_SLT: out = {{(DATA_W-1){1'b0}}, ($signed(in1) < $signed(opb))};
            default: out = '0;
        endcase
        zero = (out == '0);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports:
//   - clk: rising-edge clock.
//   - reset: synchronous, active-high.
//   - bus: request and response channels (slave side).
// Each accepted request is latched, executed in a single EXEC cycle, then
// held in RESP until the consumer accepts it. Only one op is ever in flight.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    alu_share_arbiter_if.slave bus
);

    state_t            state;
    state_t            next_state;
    logic              rr_ptr;
    logic              grant_any;
    logic              grant_id;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] imm_q;
    logic              alusrc_q;
    logic              id_q;

    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: is_legal = 1'b1;
            default:                                    is_legal = 1'b0;
        endcase
    endfunction

    // The ALU only ever sees the operand registers, so requester inputs are
    // free to change outside the handshake cycle.
    alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
        .alucontrol (op_q),
        .in1        (a_q),
        .in2        (b_q),
        .inimm      (imm_q),
        .alusrc     (alusrc_q),
        .out        (alu_out),
        .zero       (alu_zero)
    );

    // Grant only in IDLE and never while reset is asserted; under contention
    // rr_ptr names the requester whose turn it is.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == S_IDLE && !reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = rr_ptr;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
        bus.req0_ready = grant_any & ~grant_id;
        bus.req1_ready = grant_any &  grant_id;
    end

    // Next-state logic; rsp_valid is simply "in RESP".
    always_comb begin
        next_state    = state;
        bus.rsp_valid = (state == S_RESP);
        case (state)
            S_IDLE:  if (grant_any) next_state = S_EXEC;
            S_EXEC:  next_state = S_RESP;
            S_RESP:  if (bus.rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_any) begin
                rr_ptr <= ~grant_id;
            end
        end
    end

    // Operand capture on the handshake edge from whichever side was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alusrc_q <= 1'b0;
            id_q     <= 1'b0;
        end else if (grant_any) begin
            op_q     <= grant_id ? bus.req1_op     : bus.req0_op;
            a_q      <= grant_id ? bus.req1_a      : bus.req0_a;
            b_q      <= grant_id ? bus.req1_b      : bus.req0_b;
            imm_q    <= grant_id ? bus.req1_imm    : bus.req0_imm;
            alusrc_q <= grant_id ? bus.req1_alusrc : bus.req0_alusrc;
            id_q     <= grant_id;
        end
    end

    // Result capture at the end of EXEC; illegal opcodes report an error and
    // suppress whatever the ALU produced. Held untouched through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_id   <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_zero <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else if (state == S_EXEC) begin
            bus.rsp_id <= id_q;
            if (is_legal(op_q)) begin
                bus.rsp_data <= alu_out;
                bus.rsp_zero <= alu_zero;
                bus.rsp_err  <= 1'b0;
            end else begin
                bus.rsp_data <= '0;
                bus.rsp_zero <= 1'b0;
                bus.rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// falling edge, away from the rising edge.
module tb_alu_share_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_share_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

    alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_imm = '0; bus.req0_alusrc = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_imm = '0; bus.req1_alusrc = 1'b0;
    endtask

    task automatic drive_req(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic alusrc);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_imm = imm; bus.req1_alusrc = alusrc;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_imm = imm; bus.req0_alusrc = alusrc;
        end
    endtask

    // Issues one request from an idle arbiter with rsp_ready high and gathers
    // what the DUT shows in the handshake cycle, the EXEC cycle and the first
    // RESP cycle. Comparisons are done by the caller.
    task automatic issue_req(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic alusrc,
                             output logic got_ready, output logic early_valid, output logic got_valid,
                             output logic got_id, output logic [31:0] got_data, output logic got_zero, output logic got_err);
        @(negedge clk);
        drive_req(id, op, a, b, imm, alusrc);
        #1 got_ready = id ? bus.req1_ready : bus.req0_ready;
        @(negedge clk);
        clear_reqs();
        #1 early_valid = bus.rsp_valid;
        @(negedge clk);
        #1;
        got_valid = bus.rsp_valid;
        got_id    = bus.rsp_id;
        got_data  = bus.rsp_data;
        got_zero  = bus.rsp_zero;
        got_err   = bus.rsp_err;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready0: got %0b expected 0", bus.req0_ready); end
        n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready1: got %0b expected 0", bus.req1_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %0h expected 0", bus.rsp_data); end
        n_checks++; if ({bus.rsp_id, bus.rsp_zero, bus.rsp_err} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_rsp_flags: got %0b expected 000", {bus.rsp_id, bus.rsp_zero, bus.rsp_err}); end
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic r, ev, v, id, z, e;
        logic [31:0] d;
        issue_req(1'b0, 4'b0010, 32'd5, 32'd9, 32'd0, 1'b0, r, ev, v, id, d, z, e);
        n_checks++; if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ready: got %0b expected 1", r); end
        n_checks++; if (ev !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_valid: got %0b expected 0", ev); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %0b expected 1", v); end
        n_checks++; if (id !== 1'b0) begin n_fail++; $display("[TB] FAIL single_id: got %0b expected 0", id); end
        n_checks++; if (d !== 32'd14) begin n_fail++; $display("[TB] FAIL single_data: got %0d expected 14", d); end
        n_checks++; if ({z, e} !== 2'b00) begin n_fail++; $display("[TB] FAIL single_flags: got %0b expected 00", {z, e}); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_valid_drop: got %0b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_imm();
        logic r, ev, v, id, z, e;
        logic [31:0] d;
        issue_req(1'b1, 4'b0010, 32'd5, 32'd9, 32'd20, 1'b1, r, ev, v, id, d, z, e);
        n_checks++; if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL imm_ready: got %0b expected 1", r); end
        n_checks++; if (v !== 1'b1 || id !== 1'b1) begin n_fail++; $display("[TB] FAIL imm_valid_id: got %0b/%0b expected 1/1", v, id); end
        n_checks++; if (d !== 32'd25) begin n_fail++; $display("[TB] FAIL imm_data: got %0d expected 25", d); end
        issue_req(1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b0, r, ev, v, id, d, z, e);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL sub_data: got %0d expected 0", d); end
        n_checks++; if (z !== 1'b1 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL sub_flags: got z=%0b e=%0b expected z=1 e=0", z, e); end
        issue_req(1'b1, 4'b1000, 32'hFFFF_FFFD, 32'd0, 32'd2, 1'b1, r, ev, v, id, d, z, e);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("[TB] FAIL slt_signed_imm: got %0d expected 1", d); end
        issue_req(1'b0, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0, r, ev, v, id, d, z, e);
        n_checks++; if (d !== 32'h0000_00FF || id !== 1'b0) begin n_fail++; $display("[TB] FAIL or_data: got %0h id %0b expected ff id 0", d, id); end
    endtask

    // Both requesters held valid: cycles repeat IDLE/EXEC/RESP with the
    // grant alternating 0,1,0 from reset.
    task automatic test_contention();
        logic exp_id;
        pulse_reset();
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 4'b1000, 32'd5, 32'd9, 32'd0, 1'b0);
        drive_req(1'b1, 4'b1000, 32'd9, 32'd5, 32'd0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_id = ((k / 3) % 2) == 1;
            case (k % 3)
                0: begin
                    n_checks++; if (bus.req0_ready !== ~exp_id || bus.req1_ready !== exp_id) begin n_fail++; $display("[TB] FAIL contend_grant k=%0d: got r0=%0b r1=%0b expected grant %0b", k, bus.req0_ready, bus.req1_ready, exp_id); end
                end
                1: begin
                    n_checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL contend_exec k=%0d: got r0=%0b r1=%0b v=%0b expected 0 0 0", k, bus.req0_ready, bus.req1_ready, bus.rsp_valid); end
                end
                default: begin
                    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id) begin n_fail++; $display("[TB] FAIL contend_rsp k=%0d: got v=%0b id=%0b expected v=1 id=%0b", k, bus.rsp_valid, bus.rsp_id, exp_id); end
                    n_checks++; if (bus.rsp_data !== {31'd0, ~exp_id}) begin n_fail++; $display("[TB] FAIL contend_data k=%0d: got %0d expected %0d", k, bus.rsp_data, ~exp_id); end
                end
            endcase
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0);
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_first_ready: got %0b expected 1", bus.req0_ready); end
        @(negedge clk);
        drive_req(1'b0, 4'b0010, 32'd1, 32'd2, 32'd0, 1'b0);
        #1;
        n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_exec_ready: got %0b expected 0", bus.req0_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_00FF || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold i=%0d: got v=%0b d=%0h id=%0b z=%0b expected 1 ff 0 0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero); end
            n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_low i=%0d: got %0b expected 0", i, bus.req0_ready); end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_00FF) begin n_fail++; $display("[TB] FAIL bp_release: got v=%0b d=%0h expected 1 ff", bus.rsp_valid, bus.rsp_data); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_regrant: got v=%0b r0=%0b expected 0 1", bus.rsp_valid, bus.req0_ready); end
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd3) begin n_fail++; $display("[TB] FAIL bp_second: got v=%0b d=%0d expected 1 3", bus.rsp_valid, bus.rsp_data); end
    endtask

    task automatic test_illegal();
        logic r, ev, v, id, z, e;
        logic [31:0] d;
        issue_req(1'b0, 4'b1111, 32'd5, 32'd9, 32'd0, 1'b0, r, ev, v, id, d, z, e);
        n_checks++; if (v !== 1'b1 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_err: got v=%0b e=%0b expected 1 1", v, e); end
        n_checks++; if (d !== 32'd0 || z !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_data: got d=%0h z=%0b expected 0 0", d, z); end
        issue_req(1'b0, 4'b0000, 32'h0000_000C, 32'h0000_000A, 32'd0, 1'b0, r, ev, v, id, d, z, e);
        n_checks++; if (d !== 32'd8 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL after_illegal: got d=%0h e=%0b expected 8 0", d, e); end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        drive_req(1'b0, 4'b0010, 32'd1, 32'd1, 32'd0, 1'b0);
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rexec_ready: got %0b expected 1", bus.req0_ready); end
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rexec_no_rsp i=%0d: got %0b expected 0", i, bus.rsp_valid); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (bus.rsp_data !== 32'd0 || {bus.rsp_id, bus.rsp_zero, bus.rsp_err} !== 3'b000) begin n_fail++; $display("[TB] FAIL rexec_cleared: got d=%0h flags=%0b expected 0 000", bus.rsp_data, {bus.rsp_id, bus.rsp_zero, bus.rsp_err}); end
        drive_req(1'b0, 4'b0000, 32'h0000_00FF, 32'h0000_0F0F, 32'd0, 1'b0);
        drive_req(1'b1, 4'b0001, 32'd1, 32'd2, 32'd0, 1'b0);
        #1;
        n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rexec_rr_ptr: got r0=%0b r1=%0b expected 1 0", bus.req0_ready, bus.req1_ready); end
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h0000_000F) begin n_fail++; $display("[TB] FAIL rexec_resume: got v=%0b id=%0b d=%0h expected 1 0 f", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.rsp_ready = 1'b1;
        clear_reqs();
        test_reset();
        test_single();
        test_imm();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
